irq_daisy_controller: RTL and testbench
=======================================

# irq_daisy_controller

Parametrised interrupt controller between N peripheral request lines and the processor core's `irq_req_i` / `irq_ret_o` pair. It replaces the single hard-wired request with these features:
- N sources resolved by a fixed-priority daisy chain;
- per-source edge or level sensitivity;
- per-source masking from the core's `mie` CSR;
- a one-hot acknowledge pulse back to the serviced peripheral.

It holds one interrupt in service at a time; nesting is not supported.

## Interface
Parameters:
- `N_IRQ`, 16, number of sources (1..16); source 0 has highest priority.
- `EDGE_MASK`, all zeros, `N_IRQ` bits; bit i = 1 makes source i edge-sensitive, otherwise level-sensitive.
- `CAUSE_BASE`, 32'h8000_0010, `mcause` value reported for source 0.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock; everything samples on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `irq_req_i` in `N_IRQ`: peripheral request lines, synchronous to `clk_i`.
- `mie_i` in `N_IRQ`: per-source enable from the core's `mie` CSR.
- `exception_i` in 1: core is taking a synchronous exception this cycle.
- `mret_i` in 1: core executes `mret` this cycle.
- `irq_o` in/out: out 1, interrupt request to the core.
- `irq_cause_o` out 32: `mcause` value for the interrupt being raised or serviced.
- `irq_ret_o` out `N_IRQ`: one-hot acknowledge to the serviced source.
- `pending_o` out `N_IRQ`: effective pending vector, for CSR/debug visibility.

## Operation
Pending logic:
- `req_q`: register of `irq_req_i` from the previous cycle.
- Edge source i: `pend_q[i]` sets when `irq_req_i[i] & ~req_q[i]`. It stays set until source i is serviced and `mret_i` arrives.
- Level source i: the effective pending bit is the live `irq_req_i[i]`; its `pend_q` bit is unused and held at 0.
- `pending_o` = effective pending vector.
- `eligible` = `pending_o & mie_i`.

Daisy chain (combinational):
- `ready[0] = 1`; `ready[i+1] = ready[i] & ~eligible[i]`; `grant[i] = eligible[i] & ready[i]`.
- Exactly one grant bit is set when any source is eligible: the lowest index wins.

FSM with states IDLE, BUSY, RET:
- **IDLE**:
  - `irq_o = |eligible & ~exception_i`.
  - `irq_cause_o = CAUSE_BASE + index(grant)` when `irq_o` is 1, else 0.
  - When `irq_o` is 1, at the clock edge: capture `svc_q <= grant` and `cause_q <= irq_cause_o`, then go to BUSY.
  - `mret_i` is ignored in IDLE.
- **BUSY**:
  - `irq_o = 0`; `irq_cause_o = cause_q`.
  - New requests only accumulate in `pend_q`.
  - Changes to `mie_i` do not affect the interrupt in service.
  - On `mret_i`: clear `pend_q` bits selected by `svc_q`, then go to RET.
- **RET**:
  - `irq_ret_o = svc_q` for exactly this one cycle; `irq_o = 0`; `irq_cause_o = cause_q`.
  - Next state: IDLE.
  - `irq_ret_o` is 0 in every other state.

Arithmetic and boundary rules:
- `cause = CAUSE_BASE + i`, a 32-bit sum that wraps modulo 2^32.
- Rising edge on the serviced edge source in the same cycle as `mret_i`: set wins, and `pend_q` stays 1.
- Exception and eligible interrupt in the same IDLE cycle: the exception wins; the interrupt is re-evaluated next cycle with its pending state preserved.
- Level source: it must drop its request in the cycle after it sees `irq_ret_o`. If still high on return to IDLE, it is serviced again.
- `req_q` resets to 0, so a line already high when reset is released counts as a rising edge.

## Timing
- Reset values: state IDLE; `pend_q`, `req_q`, `svc_q`, `cause_q` all 0.
- Outputs out of reset: `irq_o` 0, `irq_cause_o` 0, `irq_ret_o` 0, `pending_o` 0 (for level sources, `pending_o` follows `irq_req_i` after reset).
- Reset in BUSY or RET: return to IDLE, discard all pending and in-service state, emit no `irq_ret_o` pulse.
- Edge source latency: rising edge of `irq_req_i` at cycle t gives `pend_q` set at t+1 and `irq_o` high in cycle t+1, if idle and enabled.
- Level source latency: request high in cycle t gives `irq_o` high in cycle t (combinational path).
- `irq_o` is high for exactly one cycle per accepted interrupt.
- Minimum spacing between two accepted interrupts: `irq_o` cycle, then ≥1 BUSY cycle, `mret_i` cycle, RET cycle, then `irq_o` possible again. Back-to-back `irq_o` pulses are therefore impossible.

## Test plan
- **Single edge source:** `N_IRQ`=16, `mie_i`=16'hFFFF, pulse `irq_req_i[3]` for 1 cycle.
  - Next cycle: `irq_o`=1 for 1 cycle, `irq_cause_o`=32'h8000_0013.
  - Assert `mret_i` 5 cycles later: RET cycle has `irq_ret_o`=16'h0008; `pending_o[3]`=0 afterwards.
- **Priority:** raise sources 2, 7, 12 together.
  - Services occur in order 2, 7, 12.
  - Causes 0x8000_0012, 0x8000_0017, 0x8000_001C.
  - Each service requires its own `mret_i`.
- **Masking:** `mie_i`=16'h0080, raise source 1 and source 7.
  - Only source 7 is serviced.
  - Source 1 stays in `pending_o`, and is serviced after setting `mie_i[1]`=1 with the controller idle.
- **Level source:** `EDGE_MASK`=0.
  - Hold `irq_req_i[5]` high until `irq_ret_o[5]`, then drop: exactly one service.
  - Hold it high past the ack: a second `irq_o` fires 1 cycle after RET.
- **Collisions:**
  - `exception_i`=1 in the cycle source 0 becomes eligible: `irq_o`=0; next cycle `irq_o`=1, cause 0x8000_0010.
  - New rising edge on the serviced edge source in the `mret_i` cycle: it is serviced again.
- **Reset mid-service:** assert `rst_i` in BUSY with sources 4 and 9 pending.
  - Next cycle: state IDLE, `pending_o`=0, `irq_ret_o`=0, `irq_cause_o`=0.

Source files
------------

// File: rtl/irq_daisy_controller.sv
// Fixed-priority daisy-chain interrupt controller: N edge/level sources,
// mie masking, single interrupt in service, one-hot acknowledge on return.
module irq_daisy_controller #(
   parameter int               N_IRQ      = 16,
   parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
   parameter logic [31:0]      CAUSE_BASE = 32'h8000_0010
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_IRQ-1:0] irq_req_i,
   input  logic [N_IRQ-1:0] mie_i,
   input  logic             exception_i,
   input  logic             mret_i,
   output logic             irq_o,
   output logic [31:0]      irq_cause_o,
   output logic [N_IRQ-1:0] irq_ret_o,
   output logic [N_IRQ-1:0] pending_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RET} state_t;

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   req_q, req_d;
   logic [N_IRQ-1:0]   pend_q, pend_d;
   logic [N_IRQ-1:0]   svc_q, svc_d;
   logic [31:0]        cause_q, cause_d;

   logic [N_IRQ-1:0]   eligible;
   logic [N_IRQ-1:0]   grant;
   logic [31:0]        grant_idx;
   logic [N_IRQ-1:0]   rise;
   logic [N_IRQ-1:0]   clr;
   logic               rdy;

   // Edge sources report their latched bit, level sources the live line.
   assign pending_o = (pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
   assign eligible  = pending_o & mie_i;
   assign rise      = irq_req_i & ~req_q & EDGE_MASK;
   assign req_d     = irq_req_i;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      rdy       = 1'b1;
      for (int i = 0; i < N_IRQ; i++) begin
         grant[i] = eligible[i] & rdy;
         rdy      = rdy & ~eligible[i];
         if (grant[i]) grant_idx = 32'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      svc_d       = svc_q;
      cause_d     = cause_q;
      clr         = '0;
      irq_o       = 1'b0;
      irq_cause_o = '0;
      irq_ret_o   = '0;
      case (state_q)
         IDLE: begin
            irq_o = (|eligible) & ~exception_i;
            if (irq_o) begin
               irq_cause_o = CAUSE_BASE + grant_idx;
               svc_d       = grant;
               cause_d     = irq_cause_o;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            irq_cause_o = cause_q;
            if (mret_i) begin
               clr     = svc_q;
               state_d = RET;
            end
         end
         RET: begin
            irq_cause_o = cause_q;
            irq_ret_o   = svc_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A new edge arriving with mret wins over the clear.
      pend_d = ((pend_q & ~clr) | rise) & EDGE_MASK;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= '0;
         pend_q  <= '0;
         svc_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         svc_q   <= svc_d;
         cause_q <= cause_d;
      end
   end

endmodule

// File: tb/tb_irq_daisy_controller.sv
// Bench for irq_daisy_controller: per-cycle vector table through a scoreboard
// queue, plus hand-written handshake and cause-wrap sequences.
module tb_irq_daisy_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req, mie;
   logic        exc, mret;
   logic        irq;
   logic [31:0] cause;
   logic [15:0] ret, pend;

   logic [1:0]  req2, mie2, ret2, pend2;
   logic        irq2;
   logic [31:0] cause2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Sources 0-4 and 6-15 are edge-sensitive, source 5 is level-sensitive.
   irq_daisy_controller #(
      .N_IRQ(16), .EDGE_MASK(16'hFFDF), .CAUSE_BASE(32'h8000_0010)
   ) dut (
      .clk_i(clk), .rst_i(rst), .irq_req_i(req), .mie_i(mie),
      .exception_i(exc), .mret_i(mret), .irq_o(irq), .irq_cause_o(cause),
      .irq_ret_o(ret), .pending_o(pend)
   );

   irq_daisy_controller #(
      .N_IRQ(2), .EDGE_MASK(2'b00), .CAUSE_BASE(32'hFFFF_FFFF)
   ) dut_wrap (
      .clk_i(clk), .rst_i(rst), .irq_req_i(req2), .mie_i(mie2),
      .exception_i(1'b0), .mret_i(1'b0), .irq_o(irq2), .irq_cause_o(cause2),
      .irq_ret_o(ret2), .pending_o(pend2)
   );

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic [15:0] mie;
      logic        exc;
      logic        mret;
      logic        e_irq;
      logic [31:0] e_cause;
      logic [15:0] e_ret;
      logic [15:0] e_pend;
   } vec_t;

   typedef struct {
      int          idx;
      logic        irq;
      logic [31:0] cause;
      logic [15:0] ret;
      logic [15:0] pend;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic v(input logic r, input logic [15:0] rq, input logic [15:0] m,
                    input logic e, input logic mr, input logic ei,
                    input logic [31:0] ec, input logic [15:0] er, input logic [15:0] ep);
      vec_t t;
      t.rst = r; t.req = rq; t.mie = m; t.exc = e; t.mret = mr;
      t.e_irq = ei; t.e_cause = ec; t.e_ret = er; t.e_pend = ep;
      vecs.push_back(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      bit   got;
      rst = 1'b1; req = '0; mie = 16'hFFFF; exc = 1'b0; mret = 1'b0;
      req2 = '0; mie2 = '0;

      //  rst rq       mie      exc mret irq cause          ret      pend
      // reset state, then single edge source 3
      v(1, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0008, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0008, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      // priority 2, 7, 12
      v(0, 16'h1084, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0012,  16'h0000, 16'h1084);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0012,  16'h0000, 16'h1084);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_0012,  16'h0000, 16'h1084);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0012,  16'h0004, 16'h1080);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0017,  16'h0000, 16'h1080);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_0017,  16'h0000, 16'h1080);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0017,  16'h0080, 16'h1000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_001C,  16'h0000, 16'h1000);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_001C,  16'h0000, 16'h1000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_001C,  16'h1000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      // masking: only source 7 enabled, then enable source 1
      v(0, 16'h0082, 16'h0080, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'h0080, 0, 0, 1, 32'h8000_0017,  16'h0000, 16'h0082);
      v(0, 16'h0000, 16'h0080, 0, 1, 0, 32'h8000_0017,  16'h0000, 16'h0082);
      v(0, 16'h0000, 16'h0080, 0, 0, 0, 32'h8000_0017,  16'h0080, 16'h0002);
      v(0, 16'h0000, 16'h0080, 0, 0, 0, 32'h0,          16'h0000, 16'h0002);
      v(0, 16'h0000, 16'h0082, 0, 0, 1, 32'h8000_0011,  16'h0000, 16'h0002);
      v(0, 16'h0000, 16'h0082, 0, 1, 0, 32'h8000_0011,  16'h0000, 16'h0002);
      v(0, 16'h0000, 16'h0082, 0, 0, 0, 32'h8000_0011,  16'h0002, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      // level source 5: drop after ack, then hold past ack
      v(0, 16'h0020, 16'hFFFF, 0, 0, 1, 32'h8000_0015,  16'h0000, 16'h0020);
      v(0, 16'h0020, 16'hFFFF, 0, 0, 0, 32'h8000_0015,  16'h0000, 16'h0020);
      v(0, 16'h0020, 16'hFFFF, 0, 1, 0, 32'h8000_0015,  16'h0000, 16'h0020);
      v(0, 16'h0020, 16'hFFFF, 0, 0, 0, 32'h8000_0015,  16'h0020, 16'h0020);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0020, 16'hFFFF, 0, 0, 1, 32'h8000_0015,  16'h0000, 16'h0020);
      v(0, 16'h0020, 16'hFFFF, 0, 1, 0, 32'h8000_0015,  16'h0000, 16'h0020);
      v(0, 16'h0020, 16'hFFFF, 0, 0, 0, 32'h8000_0015,  16'h0020, 16'h0020);
      v(0, 16'h0020, 16'hFFFF, 0, 0, 1, 32'h8000_0015,  16'h0000, 16'h0020);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_0015,  16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0015,  16'h0020, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      // exception collides with source 0
      v(0, 16'h0001, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 1, 0, 0, 32'h0,          16'h0000, 16'h0001);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0010,  16'h0000, 16'h0001);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_0010,  16'h0000, 16'h0001);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0010,  16'h0001, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      // new edge on serviced source 3 during mret
      v(0, 16'h0008, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0008, 16'hFFFF, 0, 1, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0008, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h8000_0013,  16'h0000, 16'h0008);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0013,  16'h0008, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      // reset while busy with sources 4 and 9 pending; mret in idle ignored
      v(0, 16'h0210, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 1, 32'h8000_0014,  16'h0000, 16'h0210);
      v(1, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h8000_0014,  16'h0000, 16'h0210);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 1, 0, 32'h0,          16'h0000, 16'h0000);
      v(0, 16'h0000, 16'hFFFF, 0, 0, 0, 32'h0,          16'h0000, 16'h0000);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         exp_t x;
         rst  = vecs[i].rst;  req  = vecs[i].req;  mie = vecs[i].mie;
         exc  = vecs[i].exc;  mret = vecs[i].mret;
         x.idx = i; x.irq = vecs[i].e_irq; x.cause = vecs[i].e_cause;
         x.ret = vecs[i].e_ret; x.pend = vecs[i].e_pend;
         sb.push_back(x);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("v%0d_irq", e.idx),     32'(irq),   32'(e.irq));
         chk($sformatf("v%0d_cause", e.idx),   cause,      e.cause);
         chk($sformatf("v%0d_ret", e.idx),     32'(ret),   32'(e.ret));
         chk($sformatf("v%0d_pending", e.idx), 32'(pend),  32'(e.pend));
         @(posedge clk);
         #1;
      end
      rst = 1'b0; req = '0; mie = 16'hFFFF; exc = 1'b0; mret = 1'b0;

      // handshake on source 11 with bounded waits
      @(posedge clk); #1;
      req = 16'h0800;
      @(posedge clk); #1;
      req = 16'h0000;
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (irq) begin
            got = 1'b1;
            break;
         end
      end
      chk("hs_irq_seen", 32'(got), 32'd1);
      chk("hs_cause", cause, 32'h8000_001B);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hs_busy_irq_low", 32'(irq), 32'd0);
      @(posedge clk); #1;
      mret = 1'b1;
      @(posedge clk); #1;
      mret = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ret != 16'h0) begin
            got = 1'b1;
            break;
         end
      end
      chk("hs_ret_seen", 32'(got), 32'd1);
      chk("hs_ret", 32'(ret), 32'h0000_0800);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hs_ret_one_cycle", 32'(ret), 32'd0);

      // cause arithmetic wraps modulo 2^32
      @(posedge clk); #1;
      req2 = 2'b10; mie2 = 2'b11;
      @(negedge clk);
      chk("wrap_irq", 32'(irq2), 32'd1);
      chk("wrap_cause", cause2, 32'h0000_0000);
      @(posedge clk); #1;
      req2 = 2'b00;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
